// File: rtl/spi_seq_config.sv
// SPI register-sequence loader: shifts NUM_REGS table words LSB-first, with an LE latch and a settle wait after each frame.
// Optional readback verify of every register is enabled by defining SPI_SEQ_READBACK_EN.
module spi_seq_config #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 11,
  parameter int CLK_DIV     = 4,
  parameter int LE_HIGH_CYC = 8,
  parameter int WAIT_CYC    = 600,
  parameter int IDX_W       = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_le,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MAX_A = (CLK_DIV > LE_HIGH_CYC) ? CLK_DIV : LE_HIGH_CYC;
  localparam int MAX_C = (MAX_A > WAIT_CYC) ? MAX_A : WAIT_CYC;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_WAIT, S_DONE
`ifdef SPI_SEQ_READBACK_EN
    , S_RD_CMD, S_RD_LATCH, S_RD_SHIFT, S_CHECK
`endif
  } state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [BIT_W-1:0]  r_bit, w_bit;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic              r_sclk, w_sclk, r_mosi, w_mosi, r_le, w_le;
  logic              r_busy, w_busy, r_done, w_done;
  logic              w_wait_end, w_advance;
  logic              w_unused;

`ifdef SPI_SEQ_READBACK_EN
  logic [DATA_W-1:0] r_rx, w_rx, w_cmd;
  logic              r_err, w_err;
  assign w_cmd    = DATA_W'({cfg_data[3:0], 4'hE});
  assign err      = r_err;
  assign w_unused = r_rx[0];
`else
  assign err      = 1'b0;
  assign w_unused = spi_miso;
`endif

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_bit      = r_bit;
    w_shift    = r_shift;
    w_idx      = r_idx;
    w_sclk     = r_sclk;
    w_mosi     = r_mosi;
    w_le       = r_le;
    w_busy     = r_busy;
    w_done     = r_done;
    w_wait_end = 1'b0;
    w_advance  = 1'b0;
`ifdef SPI_SEQ_READBACK_EN
    w_rx  = r_rx;
    w_err = r_err;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_idx   = '0;
          w_done  = 1'b0;
          w_busy  = 1'b1;
          w_cnt   = '0;
          w_state = S_LOAD;
`ifdef SPI_SEQ_READBACK_EN
          w_err = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        w_shift = cfg_data;
        w_mosi  = cfg_data[0];
        w_le    = 1'b0;
        w_cnt   = '0;
        w_bit   = '0;
        w_state = S_SHIFT;
      end
`ifdef SPI_SEQ_READBACK_EN
      S_SHIFT, S_RD_CMD, S_RD_SHIFT: begin
`else
      S_SHIFT: begin
`endif
        if (r_cnt != CNT_W'(CLK_DIV - 1)) begin
          w_cnt = r_cnt + 1'b1;
        end else begin
          w_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
`ifdef SPI_SEQ_READBACK_EN
            if (r_state == S_RD_SHIFT) w_rx = {spi_miso, r_rx[DATA_W-1:1]};
`endif
          end else begin
            // Data only moves on the falling edge so the slave sees it stable at the rise.
            w_sclk = 1'b0;
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              w_bit   = '0;
              w_mosi  = 1'b0;
              w_le    = 1'b1;
              w_state = S_LATCH;
`ifdef SPI_SEQ_READBACK_EN
              if (r_state == S_RD_CMD) w_state = S_RD_LATCH;
              else if (r_state == S_RD_SHIFT) w_state = S_CHECK;
`endif
            end else begin
              w_bit   = r_bit + 1'b1;
              w_shift = {r_shift[0], r_shift[DATA_W-1:1]};
              w_mosi  = r_shift[1];
            end
          end
        end
      end
      S_LATCH: begin
        if (r_cnt == CNT_W'(LE_HIGH_CYC - 1)) begin
          w_cnt = '0;
          if (WAIT_CYC == 0) w_wait_end = 1'b1;
          else w_state = S_WAIT;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(WAIT_CYC - 1)) begin
          w_cnt      = '0;
          w_wait_end = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
`ifdef SPI_SEQ_READBACK_EN
      S_RD_LATCH: begin
        if (r_cnt == CNT_W'(LE_HIGH_CYC - 1)) begin
          w_cnt   = '0;
          w_shift = '0;
          w_mosi  = 1'b0;
          w_le    = 1'b0;
          w_bit   = '0;
          w_state = S_RD_SHIFT;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_CHECK: begin
        // The low nibble carries the chip's address field, so only the payload is compared.
        if (r_rx[DATA_W-1:4] != cfg_data[DATA_W-1:4]) w_err = 1'b1;
        w_advance = 1'b1;
      end
`endif
      default: w_state = S_IDLE;
    endcase

    if (w_wait_end) begin
`ifdef SPI_SEQ_READBACK_EN
      w_shift = w_cmd;
      w_mosi  = w_cmd[0];
      w_le    = 1'b0;
      w_bit   = '0;
      w_state = S_RD_CMD;
`else
      w_advance = 1'b1;
`endif
    end
    if (w_advance) begin
      if (r_idx == LAST_IDX) begin
        w_state = S_DONE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end else begin
        w_idx   = r_idx + 1'b1;
        w_state = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_le    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SPI_SEQ_READBACK_EN
      r_rx    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_idx   <= w_idx;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_le    <= w_le;
      r_busy  <= w_busy;
      r_done  <= w_done;
`ifdef SPI_SEQ_READBACK_EN
      r_rx    <= w_rx;
      r_err   <= w_err;
`endif
    end
  end

  assign cfg_idx  = r_idx;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_le   = r_le;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_spi_seq_config.sv
// Bench for spi_seq_config: SPI slave monitors capture frames and are compared against a
// table-driven frame/timing model; covers a 3-entry config and a 1-entry CLK_DIV=1 config.
`timescale 1ns/1ps
module tb_spi_seq_config;
  localparam int AW = 32, AN = 3, AD = 2, AL = 8, AWT = 10;
  localparam int BW = 16, BN = 1, BD = 1, BL = 3, BWT = 0;
  localparam int SA = 2 * AD * AW;
  localparam int SB = 2 * BD * BW;
`ifdef SPI_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // DUT A: three-entry table
  logic [1:0]  cfg_idx_a;
  logic [31:0] cfg_data_a;
  logic        spi_clk_a, spi_mosi_a, spi_miso_a, spi_le_a, busy_a, done_a, err_a;
  logic [31:0] tbl_a [0:2];
  logic [31:0] resp_a [0:2];
  assign cfg_data_a = tbl_a[cfg_idx_a];

  spi_seq_config #(.DATA_W(AW), .NUM_REGS(AN), .CLK_DIV(AD), .LE_HIGH_CYC(AL), .WAIT_CYC(AWT)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_idx(cfg_idx_a), .cfg_data(cfg_data_a),
    .spi_clk(spi_clk_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso_a), .spi_le(spi_le_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  // DUT B: single entry, fastest clock, no settle wait
  logic        cfg_idx_b;
  logic [15:0] cfg_data_b;
  logic        spi_clk_b, spi_mosi_b, spi_miso_b, spi_le_b, busy_b, done_b, err_b;
  logic [15:0] tbl_b, resp_b;
  assign cfg_data_b = cfg_idx_b ? 16'hDEAD : tbl_b;

  spi_seq_config #(.DATA_W(BW), .NUM_REGS(BN), .CLK_DIV(BD), .LE_HIGH_CYC(BL), .WAIT_CYC(BWT)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_idx(cfg_idx_b), .cfg_data(cfg_data_b),
    .spi_clk(spi_clk_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso_b), .spi_le(spi_le_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  // Slave monitor A
  logic [31:0] cap_a;
  int nbit_a = 0, low_a = 0, fcnt_a = 0, edges_a = 0, mosi_viol_a = 0;
  logic pmosi_a = 1'b0;
  logic [31:0] fw_a[$];
  int fb_a[$], fl_a[$];
  always @(negedge spi_le_a) begin cap_a = '0; nbit_a = 0; low_a = 0; end
  always @(posedge spi_clk_a) begin
    edges_a++;
    if (!spi_le_a) begin
      if (nbit_a < AW) cap_a[nbit_a] = spi_mosi_a;
      nbit_a++;
    end
  end
  always @(posedge spi_le_a) begin
    fw_a.push_back(cap_a); fb_a.push_back(nbit_a); fl_a.push_back(low_a); fcnt_a++;
  end
  always @(negedge clk) begin
    if (!spi_le_a) low_a++;
    if (spi_clk_a && spi_mosi_a !== pmosi_a) mosi_viol_a++;
    pmosi_a = spi_mosi_a;
  end
  logic [1:0] ridx_a;
  logic [4:0] rbit_a;
  always_comb begin
    ridx_a = 2'((fcnt_a / 3) % 3);
    rbit_a = 5'(nbit_a);
    spi_miso_a = (fcnt_a % 3 == 2) ? resp_a[ridx_a][rbit_a] : 1'b0;
  end

  // Slave monitor B, plus a check that spi_clk toggles every cycle while LE is low
  logic [15:0] cap_b;
  int nbit_b = 0, low_b = 0, fcnt_b = 0, mosi_viol_b = 0, tog_viol_b = 0;
  logic pmosi_b = 1'b0, pclk_b = 1'b0, ple_b = 1'b1;
  logic [15:0] fw_b[$];
  int fb_b[$], fl_b[$];
  always @(negedge spi_le_b) begin cap_b = '0; nbit_b = 0; low_b = 0; end
  always @(posedge spi_clk_b) begin
    if (!spi_le_b) begin
      if (nbit_b < BW) cap_b[nbit_b] = spi_mosi_b;
      nbit_b++;
    end
  end
  always @(posedge spi_le_b) begin
    fw_b.push_back(cap_b); fb_b.push_back(nbit_b); fl_b.push_back(low_b); fcnt_b++;
  end
  always @(negedge clk) begin
    if (!spi_le_b) low_b++;
    if (spi_clk_b && spi_mosi_b !== pmosi_b) mosi_viol_b++;
    if (!spi_le_b && !ple_b && spi_clk_b === pclk_b) tog_viol_b++;
    pmosi_b = spi_mosi_b; pclk_b = spi_clk_b; ple_b = spi_le_b;
  end
  logic [3:0] rbit_b;
  always_comb begin
    rbit_b = 4'(nbit_b);
    spi_miso_b = (fcnt_b % 3 == 2) ? resp_b[rbit_b] : 1'b0;
  end

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(posedge clk) #1 start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) start_b = 1'b1;
    @(posedge clk) #1 start_b = 1'b0;
  endtask

  task automatic test_reset();
    int e0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({spi_clk_a, spi_mosi_a, spi_le_a, busy_a, done_a, err_a, cfg_idx_a} !== 8'b00100000) begin
      n_fail++; $display("FAIL reset_a: got %b expected 00100000", {spi_clk_a, spi_mosi_a, spi_le_a, busy_a, done_a, err_a, cfg_idx_a});
    end
    n_tests++;
    if ({spi_clk_b, spi_mosi_b, spi_le_b, busy_b, done_b, err_b, cfg_idx_b} !== 7'b0010000) begin
      n_fail++; $display("FAIL reset_b: got %b expected 0010000", {spi_clk_b, spi_mosi_b, spi_le_b, busy_b, done_b, err_b, cfg_idx_b});
    end
    @(negedge clk) rst_n = 1'b1;
    tbl_a[0] = 32'hFFFF_FFFF; tbl_a[1] = 32'h0; tbl_a[2] = 32'h0;
    pulse_a();
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({spi_le_a, spi_clk_a, busy_a} !== 3'b100) begin
      n_fail++; $display("FAIL reset_midframe: got le/clk/busy=%b expected 100", {spi_le_a, spi_clk_a, busy_a});
    end
    e0 = edges_a;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_tests++;
    if (edges_a !== e0) begin
      n_fail++; $display("FAIL reset_no_edges: got %0d spi_clk edges expected 0", edges_a - e0);
    end
    n_tests++;
    if ({spi_le_a, busy_a, done_a} !== 3'b100) begin
      n_fail++; $display("FAIL reset_idle: got le/busy/done=%b expected 100", {spi_le_a, busy_a, done_a});
    end
  endtask

  // Runs one full sequence on DUT A; poke_busy pulses start randomly while the sequence runs.
  task automatic test_seq_a(input string name, input bit poke_busy);
    logic [31:0] exp_w[$];
    int per, cyc, first_bad, exp_err_at, err_at, mv0;
    bit exp_err;
    fw_a.delete(); fb_a.delete(); fl_a.delete(); fcnt_a = 0;
    mv0 = mosi_viol_a;
    per = 1 + SA + AL + AWT + (RB ? (2 * SA + AL + 1) : 0);
    first_bad = -1;
    for (int i = 0; i < AN; i++) begin
      exp_w.push_back(tbl_a[i]);
      if (RB) begin
        exp_w.push_back({24'h0, tbl_a[i][3:0], 4'hE});
        exp_w.push_back(32'h0);
        if (first_bad < 0 && resp_a[i][31:4] != tbl_a[i][31:4]) first_bad = i;
      end
    end
    exp_err = (first_bad >= 0);
    exp_err_at = (first_bad >= 0) ? 3 * (first_bad + 1) : -1;
    pulse_a();
    n_tests++;
    if ({busy_a, done_a, err_a, cfg_idx_a} !== 5'b10000) begin
      n_fail++; $display("FAIL %s start_accept: got busy/done/err/idx=%b expected 10000", name, {busy_a, done_a, err_a, cfg_idx_a});
    end
    cyc = 0;
    err_at = -1;
    while (done_a !== 1'b1 && cyc < 20000) begin
      start_a = 1'b0;
      if (poke_busy && $urandom_range(0, 40) == 0) start_a = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (err_a === 1'b1 && err_at < 0) err_at = fcnt_a;
    end
    start_a = 1'b0;
    n_tests++;
    if (cyc !== per * AN) begin
      n_fail++; $display("FAIL %s done_time: got %0d cycles expected %0d", name, cyc, per * AN);
    end
    n_tests++;
    if ({busy_a, cfg_idx_a} !== {1'b0, 2'(AN - 1)}) begin
      n_fail++; $display("FAIL %s end_state: got busy/idx=%b expected 0%b", name, {busy_a, cfg_idx_a}, 2'(AN - 1));
    end
    n_tests++;
    if (err_a !== exp_err || err_at !== exp_err_at) begin
      n_fail++; $display("FAIL %s err: got %b at frame %0d expected %b at frame %0d", name, err_a, err_at, exp_err, exp_err_at);
    end
    n_tests++;
    if (fw_a.size() !== exp_w.size()) begin
      n_fail++; $display("FAIL %s frame_count: got %0d expected %0d", name, fw_a.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < fw_a.size(); i++) begin
      n_tests++;
      if (fw_a[i] !== exp_w[i] || fb_a[i] !== AW || fl_a[i] !== SA) begin
        n_fail++; $display("FAIL %s frame%0d: got %h/%0d bits/le low %0d expected %h/%0d/%0d", name, i, fw_a[i], fb_a[i], fl_a[i], exp_w[i], AW, SA);
      end
    end
    n_tests++;
    if (mosi_viol_a !== mv0) begin
      n_fail++; $display("FAIL %s mosi_stable: got %0d violations expected 0", name, mosi_viol_a - mv0);
    end
    $display("[TB] %s: %0d frames in %0d cycles, err=%b", name, fw_a.size(), cyc, err_a);
  endtask

  task automatic test_single_b(input logic [15:0] word);
    logic [15:0] exp_w[$];
    int per, cyc, idx_seen, tv0, mv0;
    tbl_b = word;
    resp_b = word ^ 16'($urandom_range(0, 15));
    fw_b.delete(); fb_b.delete(); fl_b.delete(); fcnt_b = 0;
    tv0 = tog_viol_b; mv0 = mosi_viol_b;
    exp_w.push_back(word);
    if (RB) begin
      exp_w.push_back({8'h00, word[3:0], 4'hE});
      exp_w.push_back(16'h0);
    end
    per = 1 + SB + BL + BWT + (RB ? (2 * SB + BL + 1) : 0);
    pulse_b();
    n_tests++;
    if ({busy_b, done_b} !== 2'b10) begin
      n_fail++; $display("FAIL single start_accept: got busy/done=%b expected 10", {busy_b, done_b});
    end
    cyc = 0;
    idx_seen = 0;
    while (done_b !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cfg_idx_b !== 1'b0) idx_seen = 1;
    end
    n_tests++;
    if (cyc !== per || idx_seen !== 0 || busy_b !== 1'b0 || err_b !== 1'b0) begin
      n_fail++; $display("FAIL single end: got %0d cycles idx_moved=%0d busy=%b err=%b expected %0d 0 0 0", cyc, idx_seen, busy_b, err_b, per);
    end
    n_tests++;
    if (fw_b.size() !== exp_w.size()) begin
      n_fail++; $display("FAIL single frame_count: got %0d expected %0d", fw_b.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < fw_b.size(); i++) begin
      n_tests++;
      if (fw_b[i] !== exp_w[i] || fb_b[i] !== BW || fl_b[i] !== SB) begin
        n_fail++; $display("FAIL single frame%0d: got %h/%0d bits/le low %0d expected %h/%0d/%0d", i, fw_b[i], fb_b[i], fl_b[i], exp_w[i], BW, SB);
      end
    end
    n_tests++;
    if (tog_viol_b !== tv0 || mosi_viol_b !== mv0) begin
      n_fail++; $display("FAIL single clk_div1: got %0d toggle and %0d mosi violations expected 0", tog_viol_b - tv0, mosi_viol_b - mv0);
    end
    $display("[TB] single word %h: %0d frames in %0d cycles", word, fw_b.size(), cyc);
  endtask

  initial begin
    int bad;
    tbl_b = 16'h0; resp_b = 16'h0;
    for (int i = 0; i < AN; i++) begin tbl_a[i] = '0; resp_a[i] = '0; end
    test_reset();

    tbl_a[0] = 32'h81400320; tbl_a[1] = 32'h81400321; tbl_a[2] = 32'h81400302;
    resp_a[0] = tbl_a[0]; resp_a[1] = tbl_a[1]; resp_a[2] = 32'h81400312;
    test_seq_a("directed", 1'b0);
    test_seq_a("back_to_back_busy_start", 1'b1);

    for (int k = 0; k < 3; k++) begin
      bad = $urandom_range(0, AN);
      for (int i = 0; i < AN; i++) begin
        tbl_a[i] = $urandom;
        resp_a[i] = tbl_a[i] ^ 32'($urandom_range(0, 15));
      end
      if (bad < AN) resp_a[bad] = resp_a[bad] ^ (32'h1 << $urandom_range(4, 31));
      test_seq_a("random", k[0]);
    end

    for (int k = 0; k < 3; k++) test_single_b(16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_seq_config.md
Name: spi_seq_config

Overview:
- Generic SPI register-sequence loader for the board's serial-programmed clock chips (PLL/jitter-cleaner family: 32-bit LSB-first words, latch on LE rising).
- Walks an external register table of NUM_REGS words and shifts each word out with an internally divided SPI clock. Each frame is followed by an LE-high latch interval and a settle wait.
- Raises done when the whole table has been written.
- Replaces the fixed-table, fixed-width, free-running-clock config FSMs. Sits between the power-up/reset controller and the clock-chip pins.

Parameters:
- DATA_W, 32, SPI word width in bits (>=8).
- NUM_REGS, 11, number of table entries sent per sequence (>=1).
- CLK_DIV, 4, spi_clk half-period in clk cycles (>=1).
- LE_HIGH_CYC, 8, clk cycles LE is held high after each frame (>=1).
- WAIT_CYC, 600, clk cycles of settle wait after each latch (>=0).
- IDX_W, $clog2(NUM_REGS)>1?$clog2(NUM_REGS):1, table index width (derived).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sequence when not busy.
- cfg_idx  out  IDX_W  table index currently requested.
- cfg_data  in  DATA_W  table word for cfg_idx; combinational ROM, must be valid the cycle after cfg_idx changes.
- spi_clk  out  1  serial clock, idle low.
- spi_mosi  out  1  serial data, LSB first.
- spi_miso  in  1  serial readback data (used only with the optional feature).
- spi_le  out  1  latch enable, idle high, low while a frame shifts.
- busy  out  1  high from the cycle after an accepted start until done rises.
- done  out  1  level; high after the last frame's wait; cleared by the next accepted start.
- err  out  1  sticky readback mismatch flag; cleared by an accepted start.

Behaviour:
- Reset, async: spi_clk=0, spi_mosi=0, spi_le=1, busy=0, done=0, err=0, cfg_idx=0, FSM=IDLE, all counters 0.
- States: IDLE, LOAD, SHIFT, LATCH, WAIT, DONE, plus RD_CMD, RD_LATCH, RD_SHIFT, CHECK with the optional feature.
- IDLE/DONE, start=1: cfg_idx<=0, done<=0, err<=0, busy<=1, go to LOAD. start while busy is ignored.
- LOAD, 1 cycle: shift register<=cfg_data, spi_le<=0, spi_mosi<=cfg_data[0], go to SHIFT.
- SHIFT:
  - Each bit is 2*CLK_DIV cycles: spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - spi_mosi changes only at the high-to-low transition, so it is stable across each rising edge.
  - After DATA_W rising edges and the following low half: spi_clk=0, spi_le<=1, go to LATCH.
  - Exactly DATA_W spi_clk pulses per frame; spi_le low for exactly 1+DATA_W*2*CLK_DIV-... i.e. DATA_W*2*CLK_DIV cycles.
- LATCH: spi_le=1 for LE_HIGH_CYC cycles, then go to WAIT.
- WAIT: WAIT_CYC cycles (0 means go directly on).
  - If cfg_idx==NUM_REGS-1, go to DONE: busy<=0, done<=1.
  - Otherwise cfg_idx<=cfg_idx+1 and go to LOAD. The index never wraps.
- DONE holds all outputs idle until the next start.
- spi_clk is a registered output, never gated from clk.
- Reset asserted mid-frame: outputs return to reset values immediately. There is no partial-frame recovery; software re-issues start.

Optional Feature:
- Macro: SPI_SEQ_READBACK_EN.
- Defined: after each write frame's WAIT, run a readback of the same register.
  - RD_CMD: shift the read command {cfg_data[DATA_W-1:8]=0, cfg_data[3:0], 4'hE} with the same timing as SHIFT.
  - RD_LATCH: LE high for LE_HIGH_CYC cycles.
  - RD_SHIFT: LE low, DATA_W clocks, spi_mosi=0. Sample spi_miso at each spi_clk rising edge and shift it into the MSB, right-shifting, so the first bit ends in bit 0.
  - CHECK: compare rx[DATA_W-1:4] with the written word [DATA_W-1:4]. On mismatch set err=1 (sticky) and continue the sequence.
  - Then advance the index as in WAIT.
- Not defined: no read states, spi_miso unused, err tied 0.

Test Plan:
- Reset (DATA_W=32, CLK_DIV=2, NUM_REGS=3, WAIT_CYC=10): rst_n low mid-frame -> spi_le=1, spi_clk=0, busy=0 within the same cycle; no spi_clk edges afterwards.
- Single sequence with table {32'h81400320, 32'h81400321, 32'h81400302}: slave model captures exactly 3 frames of 32 bits LSB-first matching the table; spi_le low 128 cycles per frame; done rises after the third WAIT.
- start pulsed while busy -> ignored; frame count stays 3. start in DONE -> done drops next cycle and the sequence repeats from cfg_idx=0.
- NUM_REGS=1, WAIT_CYC=0: one frame, done the cycle after LATCH ends; cfg_idx stays 0.
- CLK_DIV=1: spi_clk toggles every cycle; mosi is stable at every rising edge (checker assertion).
- SPI_SEQ_READBACK_EN: slave echoes words except frame 2 returns 32'h81400312 -> err=1 after CHECK of frame 2 and stays 1 through done; all other frames leave err=0.
